fifo_rr_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one `FIFO_Buffer` write port between `N` producers. It grants at most one producer per cycle and drives the FIFO's `wReq`/`din` from registers. Free space is tracked with a local credit counter, so it never writes into a full FIFO. It sits directly upstream of the FIFO; the consumer side (`rReq`/`dout`) is untouched, apart from a pop indication fed back for credit return.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 33 +++
 rtl/fifo_rr_write_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter: FSM encoding and
// a constant-width helper used to size the grant index and credit counter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_ERR   = 2'd2
  } arb_state_e;

  // Ceiling log2; usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 << i) < value) ? i + 1 : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of eligible_i at or above
// ptr_i, wrapping modulo N.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  int   pos_s;
  logic hit_s;

  // Scan N positions starting at the pointer; keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos_s   = 0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s   = int'(ptr_i) + k;
      pos_s   = (pos_s >= N) ? pos_s - N : pos_s;
      hit_s   = ~valid_o & eligible_i[pos_s];
      idx_o   = hit_s ? IW'(pos_s) : idx_o;
      valid_o = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N producers, with a
// local credit counter so that no word is ever written into a full FIFO.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WL    = 8,
  parameter int DEPTH = 8,
  parameter int N     = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N-1:0]                req,
  input  logic [N*WL-1:0]             data,
  input  logic                        pop,
  input  logic                        fifo_full,
  input  logic                        clr_err,
  output logic [N-1:0]                ack,
  output logic                        wReq,
  output logic [WL-1:0]               din,
  output logic [clog2(N)-1:0]         grant_id,
  output logic [clog2(DEPTH+1)-1:0]   credits,
  output logic                        err
);

  localparam int IW = clog2(N);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [N-1:0]  ONE_HOT0   = {{(N-1){1'b0}}, 1'b1};

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [CW-1:0] cred_q, cred_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          wreq_q, wreq_d;
  logic [WL-1:0] din_q, din_d;
  logic          err_q, err_d;

  logic [N-1:0]  eligible_s;
  logic          pick_valid_s;
  logic [IW-1:0] pick_idx_s;
  logic          err_hit_s;
  logic          grant_s;
  logic [CW:0]   cred_sum_s;

  // A producer acked this cycle still shows req high; mask it so it is not
  // granted twice for the same word.
  assign eligible_s = req & ~ack_q;

  rr_priority_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .eligible_i (eligible_s),
    .ptr_i      (ptr_q),
    .valid_o    (pick_valid_s),
    .idx_o      (pick_idx_s)
  );

  // Grant decision, credit update and next FSM state.
  always_comb begin
    err_hit_s = wreq_q & fifo_full;
    grant_s   = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: grant_s = pick_valid_s & ~err_hit_s & ((cred_q != '0) | pop);
      ST_ERR:           grant_s = 1'b0;
      default:          grant_s = 1'b0;
    endcase

    // A pop with the counter already full has nothing to return.
    cred_sum_s = {1'b0, cred_q} + {{CW{1'b0}}, pop} - {{CW{1'b0}}, grant_s};
    if (cred_sum_s > {1'b0, CREDIT_MAX}) begin
      cred_d = CREDIT_MAX;
    end else begin
      cred_d = cred_sum_s[CW-1:0];
    end

    state_d = state_q;
    if (err_hit_s) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_ERR:           state_d = clr_err ? ((cred_d == '0) ? ST_STALL : ST_RUN) : ST_ERR;
        ST_RUN, ST_STALL: state_d = (cred_d == '0) ? ST_STALL : ST_RUN;
        default:          state_d = ST_RUN;
      endcase
    end
    err_d = (state_d == ST_ERR);
  end

  // Next values of the registered FIFO-side outputs and the rotation pointer.
  always_comb begin
    ack_d  = '0;
    wreq_d = grant_s;
    din_d  = din_q;
    gid_d  = gid_q;
    ptr_d  = ptr_q;
    if (grant_s) begin
      ack_d = ONE_HOT0 << pick_idx_s;
      din_d = data[pick_idx_s*WL +: WL];
      gid_d = pick_idx_s;
      ptr_d = (pick_idx_s == IW'(N - 1)) ? '0 : pick_idx_s + IW'(1);
    end else begin
      ack_d = '0;
    end
  end

  // State and output registers; reset discards any in-flight grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      gid_q   <= '0;
      cred_q  <= CREDIT_MAX;
      ack_q   <= '0;
      wreq_q  <= 1'b0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cred_q  <= cred_d;
      ack_q   <= ack_d;
      wreq_q  <= wreq_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  assign ack      = ack_q;
  assign wReq     = wreq_q;
  assign din      = din_q;
  assign grant_id = gid_q;
  assign credits  = cred_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Self-checking bench for fifo_rr_write_arbiter: directed scenarios followed by
// randomized producers, all compared against a cycle-level behavioural model.
module tb_fifo_rr_write_arbiter;

  localparam int WL    = 8;
  localparam int DEPTH = 8;
  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int CW    = 4;

  localparam int M_RUN   = 0;
  localparam int M_STALL = 1;
  localparam int M_ERR   = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  req;
  logic [N*WL-1:0] data;
  logic          pop;
  logic          fifo_full;
  logic          clr_err;
  logic [N-1:0]  ack;
  logic          wReq;
  logic [WL-1:0] din;
  logic [IW-1:0] grant_id;
  logic [CW-1:0] credits;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int            m_credits;
  int            m_ptr;
  int            m_mode;
  int            m_gid;
  logic [N-1:0]  m_ack;
  bit            m_wreq;
  logic [WL-1:0] m_din;

  fifo_rr_write_arbiter #(.WL(WL), .DEPTH(DEPTH), .N(N)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .data      (data),
    .pop       (pop),
    .fifo_full (fifo_full),
    .clr_err   (clr_err),
    .ack       (ack),
    .wReq      (wReq),
    .din       (din),
    .grant_id  (grant_id),
    .credits   (credits),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits = DEPTH;
    m_ptr     = 0;
    m_mode    = M_RUN;
    m_gid     = 0;
    m_ack     = '0;
    m_wreq    = 1'b0;
    m_din     = '0;
  endtask

  task automatic check_outputs();
    check("ack", 32'(ack), 32'(m_ack));
    check("wReq", 32'(wReq), 32'(m_wreq));
    if (m_wreq) check("din", 32'(din), 32'(m_din));
    check("grant_id", 32'(grant_id), m_gid);
    check("credits", 32'(credits), m_credits);
    check("err", 32'(err), 32'(m_mode == M_ERR));
  endtask

  // One clock: predict from the present inputs, clock, compare, return at negedge.
  task automatic cycle();
    int winner;
    int c_next;
    int mode_next;
    int p;
    bit detect;
    logic [N-1:0] elig;
    detect = m_wreq && fifo_full;
    elig   = req & ~m_ack;
    winner = -1;
    if (!detect && m_mode != M_ERR && (m_credits > 0 || pop)) begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (winner < 0 && elig[p]) winner = p;
      end
    end
    c_next = m_credits - ((winner >= 0) ? 1 : 0) + (pop ? 1 : 0);
    if (c_next > DEPTH) c_next = DEPTH;
    if (detect) mode_next = M_ERR;
    else if (m_mode == M_ERR) mode_next = clr_err ? ((c_next == 0) ? M_STALL : M_RUN) : M_ERR;
    else mode_next = (c_next == 0) ? M_STALL : M_RUN;
    m_ack  = '0;
    m_wreq = (winner >= 0);
    if (winner >= 0) begin
      m_ack[winner] = 1'b1;
      m_din = data[winner*WL +: WL];
      m_gid = winner;
      m_ptr = (winner + 1) % N;
    end
    m_credits = c_next;
    m_mode    = mode_next;
    @(posedge CLK);
    #1;
    check_outputs();
    @(negedge CLK);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic apply_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("rst_credits", 32'(credits), DEPTH);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Random producers: an acked producer either retires or posts a new word.
  task automatic producers();
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
        else data[i*WL +: WL] = WL'($urandom);
      end else if (!req[i] && $urandom_range(9, 0) < 4) begin
        req[i] = 1'b1;
        data[i*WL +: WL] = WL'($urandom);
      end
    end
  endtask

  initial begin
    RST = 1'b1; req = '0; data = '0; pop = 1'b0; fifo_full = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_outputs();
    RST = 1'b0;

    // Single producer: grant every other cycle
    req = 4'b0100;
    data[2*WL +: WL] = 8'h5A;
    repeat (6) cycle();
    check("single_credits", 32'(credits), 5);

    // Fairness with a pop each cycle, then reset while wReq is high
    apply_reset();
    req  = 4'b1111;
    data = {8'd4, 8'd3, 8'd2, 8'd1};
    pop  = 1'b1;
    repeat (9) cycle();
    pop = 1'b0;
    apply_reset();

    // Fill to zero credits, stall, one pop releases exactly one grant
    repeat (11) cycle();
    check("stall_credits", 32'(credits), 0);
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    repeat (3) cycle();

    // Return three credits, then grant and pop together
    req = '0;
    pop = 1'b1;
    repeat (3) cycle();
    check("refill_credits", 32'(credits), 3);
    req = 4'b0001;
    cycle();
    check("grant_pop_credits", 32'(credits), 3);

    // Error path: Full seen with wReq
    pop = 1'b0;
    req = 4'b1111;
    cycle();
    fifo_full = 1'b1;
    cycle();
    fifo_full = 1'b0;
    repeat (2) cycle();
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    repeat (3) cycle();

    // Randomized traffic
    apply_reset();
    req = '0;
    repeat (800) begin
      pop       = ($urandom_range(99, 0) < 40);
      fifo_full = ($urandom_range(99, 0) < 3);
      clr_err   = ($urandom_range(99, 0) < 15);
      cycle();
      producers();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
